// File: rtl/lag_pl_multi_allocator.sv
// Packet-lane allocator for the LAG router: tracks output PL busy state and grants
// up to grants_per_port free PLs per output port per cycle with per-port round-robin.
module lag_pl_multi_allocator #(
    parameter int np              = 5,
    parameter int nv              = 4,
    parameter int grants_per_port = 1,
    parameter int alloc_stages    = 1,
    parameter int rr_enable       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [np*nv-1:0]      req,
    input  logic [np*nv*np-1:0]   output_port,
    input  logic [np*nv-1:0]      pl_release,
    output logic [np*nv*nv-1:0]   pl_new,
    output logic [np*nv-1:0]      pl_new_valid,
    output logic [np*nv-1:0]      pl_allocated,
    output logic [np*nv-1:0]      pl_free
);

    localparam int nr = np * nv;
    localparam int pw = (nr > 1) ? $clog2(nr) : 1;

    logic [nr-1:0]    busy;
    logic [nr-1:0]    in_flight;
    logic [pw-1:0]    rr_ptr   [np];
    logic [pw-1:0]    next_ptr [np];

    logic [nr*nv-1:0] arb_new;
    logic [nr-1:0]    arb_valid;
    logic [nr-1:0]    arb_alloc;

    logic [nr*nv-1:0] sel_new;
    logic [nr-1:0]    sel_valid;
    logic [nr-1:0]    sel_alloc;

    // Each winner in scan order takes the lowest PL still unclaimed this cycle,
    // which hands the n-th winner the n-th lowest free PL.
    always_comb begin
        logic [nv-1:0] avail;
        int            granted;
        int            r;
        logic          taken;
        avail     = '0;
        granted   = 0;
        r         = 0;
        taken     = 1'b0;
        arb_new   = '0;
        arb_valid = '0;
        arb_alloc = '0;
        for (int p = 0; p < np; p++) begin
            avail       = ~busy[p*nv +: nv];
            granted     = 0;
            next_ptr[p] = rr_ptr[p];
            for (int off = 0; off < nr; off++) begin
                r = (rr_enable != 0) ? int'(rr_ptr[p]) + off : off;
                if (r >= nr) r = r - nr;
                if (req[r] && output_port[r*np + p] && !in_flight[r] &&
                    (granted < grants_per_port) && (avail != '0)) begin
                    taken = 1'b0;
                    for (int v = 0; v < nv; v++) begin
                        if (avail[v] && !taken) begin
                            taken                 = 1'b1;
                            avail[v]              = 1'b0;
                            arb_new[r*nv + v]     = 1'b1;
                            arb_alloc[p*nv + v]   = 1'b1;
                        end
                    end
                    arb_valid[r] = 1'b1;
                    granted      = granted + 1;
                    next_ptr[p]  = (r == nr - 1) ? '0 : pw'(r + 1);
                end
            end
        end
    end

    // Allocation wins over a same-cycle release of the same PL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
            for (int p = 0; p < np; p++) rr_ptr[p] <= '0;
        end else begin
            busy <= (busy & ~pl_release) | arb_alloc;
            for (int p = 0; p < np; p++) rr_ptr[p] <= next_ptr[p];
        end
    end

    generate
        if (alloc_stages == 2) begin : g_two_stage
            logic [nr*nv-1:0] s2_new;
            logic [nr-1:0]    s2_valid;
            logic [nr-1:0]    s2_alloc;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s2_new   <= '0;
                    s2_valid <= '0;
                    s2_alloc <= '0;
                end else begin
                    s2_new   <= arb_new;
                    s2_valid <= arb_valid;
                    s2_alloc <= arb_alloc;
                end
            end

            // A requester whose grant is on the outputs sits out arbitration that cycle.
            assign in_flight = s2_valid;
            assign sel_new   = s2_new;
            assign sel_valid = s2_valid;
            assign sel_alloc = s2_alloc;
        end else begin : g_one_stage
            assign in_flight = '0;
            assign sel_new   = arb_new;
            assign sel_valid = arb_valid;
            assign sel_alloc = arb_alloc;
        end
    endgenerate

    assign pl_new       = rst_n ? sel_new   : '0;
    assign pl_new_valid = rst_n ? sel_valid : '0;
    assign pl_allocated = rst_n ? sel_alloc : '0;
    assign pl_free      = ~busy;

endmodule

// File: tb/tb_lag_pl_multi_allocator.sv
// Directed bench for lag_pl_multi_allocator: three instances (baseline, two grants
// per port, registered grants) checked against a queue of expected grant sets.
module tb_lag_pl_multi_allocator;

    localparam int NP = 5;
    localparam int NV = 4;
    localparam int NR = NP * NV;

    typedef struct {
        logic [NR*NV-1:0] pnew;
        logic [NR-1:0]    valid;
        logic [NR-1:0]    alloc;
    } grant_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req   [3];
    logic [NR*NP-1:0] oport [3];
    logic [NR-1:0]    rel   [3];
    logic [NR*NV-1:0] pnew  [3];
    logic [NR-1:0]    valid [3];
    logic [NR-1:0]    alloc [3];
    logic [NR-1:0]    free  [3];

    grant_t sb[$];
    int     tests_run    = 0;
    int     tests_failed = 0;

    always #5 clk = ~clk;

    lag_pl_multi_allocator #(.np(NP), .nv(NV), .grants_per_port(1), .alloc_stages(1), .rr_enable(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .output_port(oport[0]), .pl_release(rel[0]),
        .pl_new(pnew[0]), .pl_new_valid(valid[0]), .pl_allocated(alloc[0]), .pl_free(free[0]));

    lag_pl_multi_allocator #(.np(NP), .nv(NV), .grants_per_port(2), .alloc_stages(1), .rr_enable(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .output_port(oport[1]), .pl_release(rel[1]),
        .pl_new(pnew[1]), .pl_new_valid(valid[1]), .pl_allocated(alloc[1]), .pl_free(free[1]));

    lag_pl_multi_allocator #(.np(NP), .nv(NV), .grants_per_port(1), .alloc_stages(2), .rr_enable(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .output_port(oport[2]), .pl_release(rel[2]),
        .pl_new(pnew[2]), .pl_new_valid(valid[2]), .pl_allocated(alloc[2]), .pl_free(free[2]));

    function automatic logic [NR-1:0] b(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NR*NP-1:0] route(input int r, input int p);
        logic [NR*NP-1:0] v;
        v           = '0;
        v[r*NP + p] = 1'b1;
        return v;
    endfunction

    function automatic logic [NR*NV-1:0] pl(input int r, input int v);
        logic [NR*NV-1:0] x;
        x           = '0;
        x[r*NV + v] = 1'b1;
        return x;
    endfunction

    // Every active requester must name exactly one output port.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < NR; r++) begin
                if (req[d][r] === 1'b1) begin
                    tests_run++;
                    assert ($onehot(oport[d][r*NP +: NP])) else begin
                        tests_failed++;
                        $error("[TB] FAIL onehot dut%0d req%0d observed %b expected one-hot", d, r, oport[d][r*NP +: NP]);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input logic rst, input logic [NR-1:0] rq,
                                 input logic [NR*NP-1:0] op, input logic [NR-1:0] rl,
                                 input logic [NR*NV-1:0] e_new, input logic [NR-1:0] e_valid,
                                 input logic [NR-1:0] e_alloc);
        grant_t g;
        @(posedge clk);
        #1;
        rst_n = rst;
        for (int k = 0; k < 3; k++) begin
            req[k]   = '0;
            oport[k] = '0;
            rel[k]   = '0;
        end
        req[d]   = rq;
        oport[d] = op;
        rel[d]   = rl;
        g.pnew   = e_new;
        g.valid  = e_valid;
        g.alloc  = e_alloc;
        sb.push_back(g);
    endtask

    task automatic checkOutput(input int d, input string tag, input logic [NR-1:0] e_free);
        grant_t g;
        @(negedge clk);
        tests_run++;
        assert (sb.size() != 0) else begin
            tests_failed++;
            $error("[TB] FAIL %s scoreboard observed empty expected entry", tag);
        end
        if (sb.size() != 0) begin
            g = sb.pop_front();
            tests_run++;
            assert (pnew[d] === g.pnew) else begin
                tests_failed++;
                $error("[TB] FAIL %s pl_new observed %h expected %h", tag, pnew[d], g.pnew);
            end
            tests_run++;
            assert (valid[d] === g.valid) else begin
                tests_failed++;
                $error("[TB] FAIL %s pl_new_valid observed %h expected %h", tag, valid[d], g.valid);
            end
            tests_run++;
            assert (alloc[d] === g.alloc) else begin
                tests_failed++;
                $error("[TB] FAIL %s pl_allocated observed %h expected %h", tag, alloc[d], g.alloc);
            end
        end
        tests_run++;
        assert (free[d] === e_free) else begin
            tests_failed++;
            $error("[TB] FAIL %s pl_free observed %h expected %h", tag, free[d], e_free);
        end
    endtask

    initial begin
        logic [NR-1:0]    z;
        logic [NR*NV-1:0] zn;
        logic [NR-1:0]    all1;
        logic [NR-1:0]    rq4;
        logic [NR*NP-1:0] op4;
        logic [NR-1:0]    f1;
        logic [NR*NP-1:0] op3;
        grant_t           zg;

        z    = '0;
        zn   = '0;
        all1 = '1;
        rq4  = b(0) | b(4) | b(8) | b(12);
        op4  = route(0, 1) | route(4, 1) | route(8, 1) | route(12, 1);
        f1   = ~(b(4) | b(5) | b(6) | b(7) | b(8));
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k]   = '0;
            oport[k] = '0;
            rel[k]   = '0;
        end
        repeat (2) @(posedge clk);

        // Baseline instance: reset, single grant, round-robin sweep, release timing.
        applyStimulus(0, 1'b0, b(0), route(0, 2), z, zn, z, z);
        checkOutput(0, "a_in_reset", all1);
        applyStimulus(0, 1'b1, b(0), route(0, 2), z, pl(0, 0), b(0), b(8));
        checkOutput(0, "a_single", all1);
        applyStimulus(0, 1'b1, z, '0, z, zn, z, z);
        checkOutput(0, "a_single_busy", ~b(8));
        applyStimulus(0, 1'b1, rq4, op4, z, pl(0, 0), b(0), b(4));
        checkOutput(0, "a_rr0", ~b(8));
        applyStimulus(0, 1'b1, rq4, op4, z, pl(4, 1), b(4), b(5));
        checkOutput(0, "a_rr4", ~(b(8) | b(4)));
        applyStimulus(0, 1'b1, rq4, op4, z, pl(8, 2), b(8), b(6));
        checkOutput(0, "a_rr8", ~(b(8) | b(4) | b(5)));
        applyStimulus(0, 1'b1, rq4, op4, z, pl(12, 3), b(12), b(7));
        checkOutput(0, "a_rr12", ~(b(8) | b(4) | b(5) | b(6)));
        applyStimulus(0, 1'b1, rq4, op4, z, zn, z, z);
        checkOutput(0, "a_port_full", f1);
        applyStimulus(0, 1'b1, rq4, op4, b(6), zn, z, z);
        checkOutput(0, "a_release_cycle", f1);
        applyStimulus(0, 1'b1, rq4, op4, z, pl(0, 2), b(0), b(6));
        checkOutput(0, "a_after_release", ~(b(4) | b(5) | b(7) | b(8)));
        op3 = route(3, 0);
        applyStimulus(0, 1'b1, b(3), op3, b(0) | b(9), pl(3, 0), b(3), b(0));
        checkOutput(0, "a_alloc_vs_release", f1);
        applyStimulus(0, 1'b1, z, '0, z, zn, z, z);
        checkOutput(0, "a_alloc_wins", f1 & ~b(0));
        applyStimulus(0, 1'b0, b(1), route(1, 3), z, zn, z, z);
        checkOutput(0, "a_mid_reset", f1 & ~b(0));
        applyStimulus(0, 1'b1, z, '0, z, zn, z, z);
        checkOutput(0, "a_after_reset", all1);

        // Two grants per port: PL ordering among winners and pointer advance.
        applyStimulus(1, 1'b1, b(5) | b(6), route(5, 0) | route(6, 0), z,
                      pl(5, 0) | pl(6, 1), b(5) | b(6), b(0) | b(1));
        checkOutput(1, "b_pair", all1);
        applyStimulus(1, 1'b1, b(7), route(7, 0), b(1), pl(7, 2), b(7), b(2));
        checkOutput(1, "b_fill", ~(b(0) | b(1)));
        applyStimulus(1, 1'b1, b(2) | b(10) | b(15), route(2, 0) | route(10, 0) | route(15, 0), z,
                      pl(10, 1) | pl(15, 3), b(10) | b(15), b(1) | b(3));
        checkOutput(1, "b_three_two_free", ~(b(0) | b(2)));
        applyStimulus(1, 1'b1, z, '0, b(1) | b(3), zn, z, z);
        checkOutput(1, "b_release", ~(b(0) | b(1) | b(2) | b(3)));
        applyStimulus(1, 1'b1, b(2) | b(10) | b(16), route(2, 0) | route(10, 0) | route(16, 0), z,
                      pl(16, 1) | pl(2, 3), b(2) | b(16), b(1) | b(3));
        checkOutput(1, "b_rr_wrap", ~(b(0) | b(2)));

        // Registered grants: one-cycle latency, in-flight masking, re-request.
        zg = '{pnew: '0, valid: '0, alloc: '0};
        sb.push_back(zg);
        applyStimulus(2, 1'b1, b(0), route(0, 2), z, pl(0, 0), b(0), b(8));
        checkOutput(2, "c_arb_cycle", all1);
        applyStimulus(2, 1'b1, b(0), route(0, 2), z, zn, z, z);
        checkOutput(2, "c_grant_visible", ~b(8));
        applyStimulus(2, 1'b1, b(0), route(0, 2), z, pl(0, 1), b(0), b(9));
        checkOutput(2, "c_no_double", ~b(8));
        applyStimulus(2, 1'b1, z, '0, z, zn, z, z);
        checkOutput(2, "c_new_request", ~(b(8) | b(9)));
        applyStimulus(2, 1'b1, z, '0, z, zn, z, z);
        checkOutput(2, "c_idle", ~(b(8) | b(9)));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lag_pl_multi_allocator.md
Name: lag_pl_multi_allocator

Overview:
Next-generation packet-lane (PL) allocator for the LAG router. It keeps its own per-output-port PL busy/free state, so callers no longer supply a status vector. It arbitrates all input PLs requesting each output port with per-port round-robin, and can grant up to grants_per_port PLs per output port per cycle. The arbitration-to-grant path can be one stage (grant in the request cycle) or two stages (registered grant). It sits between the route stage and switch allocation in each router.

Parameters:
np, 5, number of router ports (input = output count)
nv, 4, PLs per port
grants_per_port, 1, max PLs granted per output port per cycle (1..nv)
alloc_stages, 1, 1 = grant visible in request cycle; 2 = grant registered, visible next cycle
rr_enable, 1, 1 = round-robin requester priority per output port; 0 = fixed priority, lowest flat index wins

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req  input  np*nv  request from input PL (i,j), flat index i*nv+j
output_port  input  np*nv*np  one-hot requested output port per input PL
pl_release  input  np*nv  pulse: output PL (p,v) returns to free (tail left)
pl_new  output  np*nv*nv  one-hot output PL granted to input PL (i,j)
pl_new_valid  output  np*nv  grant valid for input PL (i,j)
pl_allocated  output  np*nv  output PL (p,v) allocated this cycle
pl_free  output  np*nv  registered free status of output PL (p,v)

Behaviour:
- Reset (rst_n low at clk edge): all busy bits 0, so pl_free all 1. RR pointers 0, in-flight mask 0, stage-2 registers 0. While rst_n is low, pl_new, pl_new_valid and pl_allocated are forced 0. Reset mid-operation discards in-flight grants; requesters must re-request.
- Eligible requester for port p: req=1, output_port one-hot bit p=1, not in in-flight mask. output_port with zero or multiple bits set is illegal, and the bench asserts on it.
- Per port p, each cycle:
  - k = min(grants_per_port, popcount(pl_free[p]), eligible count).
  - Winners: the first k eligible requesters scanning flat index upward, starting at rr_ptr[p] (rr_enable=1) or at 0 (rr_enable=0).
  - PLs: winner n gets the n-th lowest-index free PL.
- Grant timing:
  - alloc_stages=1: pl_new/pl_new_valid/pl_allocated are combinational in the arbitration cycle.
  - alloc_stages=2: the same values are registered and appear one cycle later. Winners enter the in-flight mask for that one cycle so they cannot be re-granted.
- Status update at the edge ending the arbitration cycle, in both modes:
  - each allocated PL sets busy;
  - each released PL clears busy.
  - A PL freed by pl_release in cycle t is allocatable from cycle t+1, never in t.
  - Release of a PL that is already free: no effect.
  - Release and allocation cannot target the same PL in one cycle, because allocation needs the PL free. If the bench forces a release onto a PL being allocated in that same cycle, allocate wins and the PL ends busy.
- rr_ptr[p] update: when at least one grant is made, set to (flat index of last winner + 1) mod (np*nv). Otherwise unchanged. Wrap from np*nv-1 to 0.
- Handshake: the requester holds req until it sees pl_new_valid, then drops req in the next cycle. A req still high in the cycle after a grant (stage 1) or after the in-flight cycle (stage 2) is treated as a new request.
- pl_allocated[p*nv+v] = OR of pl_new bit v over all grants to port p in that cycle. The count of set bits per port is at most grants_per_port.
- Port p with no free PL: no grants, requesters wait, rr_ptr[p] holds.
- Ports are independent: grants to different output ports in one cycle never interact.

Test Plan:
- Reset then idle, np=5, nv=4 -> pl_free=all 1, all grant outputs 0; asserting rst_n low mid-traffic returns pl_free to all 1 at the next edge.
- Single request, input PL (0,0) to port 2, alloc_stages=1 -> same cycle pl_new[0]=4'b0001 with valid=1, pl_allocated[8]=1; next cycle pl_free[8]=0.
- Four requesters (flat 0,4,8,12) to port 1, grants_per_port=1, rr_enable=1, requests re-raised each cycle -> grants in order 0,4,8,12 using PLs 0,1,2,3. Fifth round: no grant until a pl_release.
- Port 3 fully busy, pl_release of (3,2) in cycle t with a waiting requester -> no grant in t; grant of PL 2 in t+1.
- grants_per_port=2, three requesters to port 0, two free PLs (1,3) -> two grants, the lower-RR-order winner gets PL 1, the other PL 3; the third waits; rr_ptr advances past the second winner.
- alloc_stages=2, single request -> pl_new_valid one cycle after the request; requester held high is not granted twice; pl_free drops at the edge ending the arbitration cycle.
